// File: rtl/instr_mem.sv
// Instruction memory with a streaming program loader and a 1-cycle registered
// fetch port.
//
// Ports:
//   clk, reset        clock; synchronous active-low reset
//   load_start        pulse; (re)starts a program load at address 0
//   load_valid/_data  incoming program word
//   load_last         marks the final program word
//   load_ready        high while loading (a valid word is accepted)
//   pc                fetch address from the control unit
//   instr             registered instruction word (FILL past prog_len)
//   cpu_run           high once a completed program may execute
//   prog_len          word count of the last completed load (0..256)
module instr_mem #(
    parameter int            DEPTH = 256,
    parameter int            IW    = 9,
    parameter logic [IW-1:0] FILL  = 9'h000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_start,
    input  logic          load_valid,
    input  logic [IW-1:0] load_data,
    input  logic          load_last,
    output logic          load_ready,
    input  logic [7:0]    pc,
    output logic [IW-1:0] instr,
    output logic          cpu_run,
    output logic [8:0]    prog_len
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [8:0] LAST_ADDR = 9'(DEPTH - 1);

    logic [IW-1:0] mem [0:DEPTH-1];

    state_t        state_q, state_d;
    logic [8:0]    wr_ptr_q, wr_ptr_d;
    logic [8:0]    prog_len_q, prog_len_d;
    logic          load_ready_q;
    logic          cpu_run_q;
    logic [IW-1:0] instr_q;
    logic          we;

    // A restart always wins over a word arriving in the same cycle.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        prog_len_d = prog_len_q;
        we         = 1'b0;
        if (load_start) begin
            state_d    = LOAD;
            wr_ptr_d   = 9'd0;
            prog_len_d = 9'd0;
        end else if (state_q == LOAD && load_valid) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + 9'd1;
            // The top address closes the load even without load_last.
            if (load_last || wr_ptr_q == LAST_ADDR) begin
                prog_len_d = wr_ptr_q + 9'd1;
                state_d    = RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            wr_ptr_q     <= 9'd0;
            prog_len_q   <= 9'd0;
            load_ready_q <= 1'b0;
            cpu_run_q    <= 1'b0;
            instr_q      <= FILL;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            prog_len_q   <= prog_len_d;
            load_ready_q <= (state_d == LOAD);
            // Rises one edge after RUN is entered; drops with a restart.
            cpu_run_q    <= (state_q == RUN) && (state_d == RUN);
            instr_q      <= ({1'b0, pc} < prog_len_q) ? mem[pc] : FILL;
        end
    end

    // Storage has no reset so it maps onto block RAM; contents survive reset.
    always_ff @(posedge clk) begin
        if (we && reset) begin
            mem[wr_ptr_q[7:0]] <= load_data;
        end
    end

    assign load_ready = load_ready_q;
    assign cpu_run    = cpu_run_q;
    assign instr      = instr_q;
    assign prog_len   = prog_len_q;

endmodule

// File: tb/tb_instr_mem.sv
// Self-checking bench for instr_mem: directed scenarios plus randomized
// loads checked against an array model of program contents and length.
module tb_instr_mem;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load_start = 1'b0;
    logic       load_valid = 1'b0;
    logic [8:0] load_data = 9'h000;
    logic       load_last = 1'b0;
    logic       load_ready;
    logic [7:0] pc = 8'h00;
    logic [8:0] instr;
    logic       cpu_run;
    logic [8:0] prog_len;

    int checks = 0;
    int failures = 0;

    logic [8:0] ref_mem [256];
    int ref_len = 0;
    int ref_wp = 0;

    instr_mem dut (
        .clk(clk), .reset(reset),
        .load_start(load_start), .load_valid(load_valid),
        .load_data(load_data), .load_last(load_last),
        .load_ready(load_ready), .pc(pc), .instr(instr),
        .cpu_run(cpu_run), .prog_len(prog_len)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] ref_read(input int a);
        return (a < ref_len) ? ref_mem[a] : 9'h000;
    endfunction

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        ref_len = 0;
        ref_wp = 0;
    endtask

    task automatic send(input logic [8:0] w, input bit last);
        load_valid = 1'b1;
        load_data = w;
        load_last = last;
        tick();
        load_valid = 1'b0;
        load_last = 1'b0;
        ref_mem[ref_wp] = w;
        ref_wp++;
        if (last || ref_wp == 256) ref_len = ref_wp;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        load_valid = 1'b1;
        load_start = 1'b1;
        tick();
        tick();
        load_start = 1'b0;
        load_valid = 1'b0;
        checks++;
        if (load_ready !== 1'b0 || cpu_run !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctl got rdy=%b run=%b want 0 0",
                     load_ready, cpu_run);
        end
        checks++;
        if (prog_len !== 9'd0 || instr !== 9'h000) begin
            failures++;
            $display("FAIL reset_data got len=%0d instr=%h want 0 000",
                     prog_len, instr);
        end
        reset = 1'b1;
        load_valid = 1'b1;
        load_data = 9'h1FF;
        tick();
        tick();
        load_valid = 1'b0;
        checks++;
        if (load_ready !== 1'b0 || prog_len !== 9'd0) begin
            failures++;
            $display("FAIL idle_ignore got rdy=%b len=%0d want 0 0",
                     load_ready, prog_len);
        end
    endtask

    task automatic test_basic();
        logic [8:0] w [4];
        w[0] = 9'h1A4; w[1] = 9'h0C9; w[2] = 9'h152; w[3] = 9'h000;
        start_load();
        checks++;
        if (load_ready !== 1'b1 || cpu_run !== 1'b0) begin
            failures++;
            $display("FAIL basic_load_state got rdy=%b run=%b want 1 0",
                     load_ready, cpu_run);
        end
        send(9'h1A4, 1'b0);
        send(9'h0C9, 1'b0);
        send(9'h152, 1'b1);
        checks++;
        if (prog_len !== 9'd3 || load_ready !== 1'b0) begin
            failures++;
            $display("FAIL basic_len got len=%0d rdy=%b want 3 0",
                     prog_len, load_ready);
        end
        tick();
        checks++;
        if (cpu_run !== 1'b1) begin
            failures++;
            $display("FAIL basic_run got %b want 1", cpu_run);
        end
        for (int i = 0; i < 4; i++) begin
            pc = 8'(i);
            tick();
            checks++;
            if (instr !== w[i]) begin
                failures++;
                $display("FAIL basic_read pc=%0d got %h want %h",
                         i, instr, w[i]);
            end
        end
    endtask

    task automatic test_stall();
        start_load();
        send(9'h011, 1'b0);
        load_data = 9'h1EE;
        tick();
        tick();
        checks++;
        if (load_ready !== 1'b1 || prog_len !== 9'd0 || cpu_run !== 1'b0) begin
            failures++;
            $display("FAIL stall_hold got rdy=%b len=%0d run=%b want 1 0 0",
                     load_ready, prog_len, cpu_run);
        end
        send(9'h022, 1'b1);
        tick();
        checks++;
        if (prog_len !== 9'd2 || cpu_run !== 1'b1) begin
            failures++;
            $display("FAIL stall_len got len=%0d run=%b want 2 1",
                     prog_len, cpu_run);
        end
        for (int i = 0; i < 3; i++) begin
            pc = 8'(i);
            tick();
            checks++;
            if (instr !== ref_read(i)) begin
                failures++;
                $display("FAIL stall_read pc=%0d got %h want %h",
                         i, instr, ref_read(i));
            end
        end
    endtask

    task automatic test_full();
        int a;
        start_load();
        for (int i = 0; i < 256; i++) begin
            send(9'($urandom_range(1, 511)), 1'b0);
            if (i == 128) begin
                checks++;
                if (load_ready !== 1'b1 || cpu_run !== 1'b0) begin
                    failures++;
                    $display("FAIL full_mid got rdy=%b run=%b want 1 0",
                             load_ready, cpu_run);
                end
            end
        end
        checks++;
        if (prog_len !== 9'd256 || load_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_len got len=%0d rdy=%b want 256 0",
                     prog_len, load_ready);
        end
        // Further words in RUN must be ignored (no wrap to address 0).
        load_valid = 1'b1;
        load_data = 9'h000;
        tick();
        tick();
        load_valid = 1'b0;
        checks++;
        if (cpu_run !== 1'b1) begin
            failures++;
            $display("FAIL full_run got %b want 1", cpu_run);
        end
        pc = 8'd255;
        tick();
        checks++;
        if (instr !== ref_mem[255]) begin
            failures++;
            $display("FAIL full_last got %h want %h", instr, ref_mem[255]);
        end
        pc = 8'd0;
        tick();
        checks++;
        if (instr !== ref_mem[0]) begin
            failures++;
            $display("FAIL full_nowrap got %h want %h", instr, ref_mem[0]);
        end
        for (int i = 0; i < 16; i++) begin
            a = $urandom_range(0, 255);
            pc = 8'(a);
            tick();
            checks++;
            if (instr !== ref_read(a)) begin
                failures++;
                $display("FAIL full_rand pc=%0d got %h want %h",
                         a, instr, ref_read(a));
            end
        end
    endtask

    task automatic test_restart();
        start_load();
        checks++;
        if (cpu_run !== 1'b0 || load_ready !== 1'b1 || prog_len !== 9'd0) begin
            failures++;
            $display("FAIL restart_enter got run=%b rdy=%b len=%0d want 0 1 0",
                     cpu_run, load_ready, prog_len);
        end
        tick();
        checks++;
        if (cpu_run !== 1'b0) begin
            failures++;
            $display("FAIL restart_stall_run got %b want 0", cpu_run);
        end
        send(9'h0F0, 1'b1);
        checks++;
        if (prog_len !== 9'd1) begin
            failures++;
            $display("FAIL restart_len got %0d want 1", prog_len);
        end
        tick();
        pc = 8'd0;
        tick();
        checks++;
        if (instr !== 9'h0F0 || cpu_run !== 1'b1) begin
            failures++;
            $display("FAIL restart_pc0 got %h run=%b want 0f0 1",
                     instr, cpu_run);
        end
        pc = 8'd1;
        tick();
        checks++;
        if (instr !== 9'h000) begin
            failures++;
            $display("FAIL restart_fill got %h want 000", instr);
        end
    endtask

    task automatic test_back_to_back();
        start_load();
        send(9'h055, 1'b0);
        // Restart coinciding with a valid last word: restart wins.
        load_start = 1'b1;
        load_valid = 1'b1;
        load_data = 9'h1FF;
        load_last = 1'b1;
        tick();
        load_start = 1'b0;
        load_valid = 1'b0;
        load_last = 1'b0;
        ref_len = 0;
        ref_wp = 0;
        checks++;
        if (load_ready !== 1'b1 || prog_len !== 9'd0) begin
            failures++;
            $display("FAIL coincide_state got rdy=%b len=%0d want 1 0",
                     load_ready, prog_len);
        end
        send(9'h0AA, 1'b1);
        checks++;
        if (prog_len !== 9'd1) begin
            failures++;
            $display("FAIL coincide_len got %0d want 1", prog_len);
        end
        pc = 8'd0;
        tick();
        checks++;
        if (instr !== 9'h0AA) begin
            failures++;
            $display("FAIL coincide_read got %h want 0aa", instr);
        end
    endtask

    task automatic test_reset_midload();
        start_load();
        send(9'h123, 1'b0);
        send(9'h0BC, 1'b0);
        reset = 1'b0;
        load_valid = 1'b1;
        load_start = 1'b1;
        load_data = 9'h1CD;
        tick();
        reset = 1'b1;
        load_valid = 1'b0;
        load_start = 1'b0;
        ref_len = 0;
        checks++;
        if (load_ready !== 1'b0 || cpu_run !== 1'b0 || prog_len !== 9'd0) begin
            failures++;
            $display("FAIL midreset got rdy=%b run=%b len=%0d want 0 0 0",
                     load_ready, cpu_run, prog_len);
        end
        for (int i = 0; i < 4; i++) begin
            pc = 8'(i);
            tick();
            checks++;
            if (instr !== 9'h000 || load_ready !== 1'b0) begin
                failures++;
                $display("FAIL midreset_read pc=%0d got %h rdy=%b want 000 0",
                         i, instr, load_ready);
            end
        end
    endtask

    task automatic test_random();
        int n;
        int a;
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(1, 40);
            start_load();
            for (int i = 0; i < n; i++) begin
                for (int s = $urandom_range(0, 2); s > 0; s--) begin
                    load_data = 9'($urandom);
                    tick();
                end
                send(9'($urandom), i == n - 1);
            end
            tick();
            checks++;
            if (prog_len !== 9'(n) || cpu_run !== 1'b1) begin
                failures++;
                $display("FAIL rand_len it=%0d got %0d run=%b want %0d 1",
                         it, prog_len, cpu_run, n);
            end
            for (int r = 0; r < 10; r++) begin
                a = $urandom_range(0, 47);
                pc = 8'(a);
                tick();
                checks++;
                if (instr !== ref_read(a)) begin
                    failures++;
                    $display("FAIL rand_read it=%0d pc=%0d got %h want %h",
                             it, a, instr, ref_read(a));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_full();
        test_restart();
        test_back_to_back();
        test_reset_midload();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
